// File: rtl/memory_rom_pkg.sv
// Shared constants for the 4 x 8-bit fixed-content ROM: geometry, contents and idle value.
package memory_rom_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 2;
  localparam int unsigned ROM_DATA_WIDTH = 8;
  localparam int unsigned ROM_DEPTH      = 1 << ROM_ADDR_WIDTH;

  typedef logic [ROM_ADDR_WIDTH-1:0] rom_addr_t;
  typedef logic [ROM_DATA_WIDTH-1:0] rom_word_t;

  localparam rom_word_t ROM_CONTENTS [ROM_DEPTH] = '{8'hA5, 8'h5A, 8'hF0, 8'h0F};

  // Value driven on the data output whenever no read is being presented.
  localparam rom_word_t ROM_IDLE_DATA = 8'h00;

  function automatic rom_word_t rom_lookup(input rom_addr_t addr);
    return ROM_CONTENTS[addr];
  endfunction

endpackage

// File: rtl/memory_rom_array.sv
// Purely combinational address-to-word lookup over the fixed ROM contents.
module memory_rom_array
  import memory_rom_pkg::*;
(
  input  rom_addr_t address,
  output rom_word_t word
);

  always_comb begin
    word = rom_lookup(address);
  end

endmodule

// File: rtl/memory_rom.sv
// Fixed-content ROM with chip select and registered data/valid outputs (one-cycle latency).
module memory_rom
  import memory_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ROM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  chip_selection,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid
);

  rom_word_t rom_word;
  rom_word_t data_d, data_q;
  logic      valid_d, valid_q;

  memory_rom_array u_array (
    .address (rom_addr_t'(address)),
    .word    (rom_word)
  );

  // Deselected cycles drive a defined zero rather than holding the last word.
  always_comb begin
    data_d  = ROM_IDLE_DATA;
    valid_d = 1'b0;
    if (chip_selection) begin
      data_d  = rom_word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= ROM_IDLE_DATA;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data       = DATA_WIDTH'(data_q);
  assign data_valid = valid_q;

endmodule

// File: tb/tb_memory_rom.sv
// Scoreboard bench for memory_rom: driver pushes expected responses, monitor pops and compares.
module tb_memory_rom;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } resp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] address = 2'd2;
  logic       chip_selection = 1'b1;
  logic [7:0] data;
  logic       data_valid;

  int checks = 0;
  int fails  = 0;

  resp_t exp_q[$];

  logic [7:0] rom_ref [4] = '{8'hA5, 8'h5A, 8'hF0, 8'h0F};

  memory_rom #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .chip_selection (chip_selection),
    .data           (data),
    .data_valid     (data_valid)
  );

  always #5 clk = ~clk;

  function automatic resp_t ref_model(input logic sel, input logic [1:0] addr);
    resp_t r;
    r.valid = sel;
    r.data  = sel ? rom_ref[addr] : 8'h00;
    return r;
  endfunction

  task automatic check(input string name, input logic v, input logic [7:0] d,
                       input logic ev, input logic [7:0] ed);
    checks++;
    if (v !== ev || d !== ed) begin
      fails++;
      $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h", name, v, d, ev, ed);
    end
  endtask

  // Drive one cycle's inputs, record the response due after the next rising edge.
  task automatic step(input logic sel, input logic [1:0] addr);
    chip_selection = sel;
    address        = addr;
    exp_q.push_back(ref_model(sel, addr));
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    resp_t e;
    #1;
    if (!reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty: got valid=%b data=%h, expected a queued response",
                 data_valid, data);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", data_valid, data, e.valid, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset while selected on address 2: outputs clear with no clock edge.
    #2 reset = 1'b1;
    #1 check("reset_async", data_valid, data, 1'b0, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", data_valid, data, 1'b0, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;

    repeat (10) step(1'b0, 2'd0);

    for (int a = 0; a < 4; a++) step(1'b1, 2'(a));

    step(1'b1, 2'd1);
    step(1'b0, 2'd1);

    // Mid-stream reset after a read of address 3 has landed on the outputs.
    step(1'b1, 2'd3);
    reset = 1'b1;
    #1 check("reset_midread", data_valid, data, 1'b0, 8'h00);
    #1 reset = 1'b0;
    step(1'b1, 2'd3);

    repeat (200) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    step(1'b0, 2'd0);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
